// File: rtl/pulse_measure.sv
// pulse_measure
//
// Arms on a start strobe and measures a single-bit pulse that is synchronous
// to clk: first the delay from start to the rising edge, then the number of
// sampling edges the pulse stays high. Both values are compared against the
// expected values and the result word is held on a valid/ready handshake
// until the consumer accepts it.
//
// Optional build macro: PULSE_MEASURE_STATS_EN adds a saturating 16-bit
// count of accepted results that carried any error flag.
//
// Ports:
//   clk          clock; all logic is rising-edge
//   reset        synchronous, active-high reset
//   start        arm request, only looked at while idle
//   pulse_in     monitored pulse, synchronous to clk
//   meas_delay   measured start-to-rise delay (clocks)
//   meas_width   measured high width (clocks)
//   delay_err    meas_delay differs from EXP_DELAY
//   width_err    meas_width differs from EXP_WIDTH
//   timeout_err  no rising edge within TIMEOUT clocks
//   meas_valid   result fields valid
//   meas_ready   consumer accepts the result
//   busy         a measurement or report is in progress
//   fail_count   (PULSE_MEASURE_STATS_EN only) accepted results with errors

module pulse_measure #(
  parameter int CNT_W     = 8,
  parameter int EXP_DELAY = 3,
  parameter int EXP_WIDTH = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] meas_delay,
  output logic [CNT_W-1:0] meas_width,
  output logic             delay_err,
  output logic             width_err,
  output logic             timeout_err,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             busy
`ifdef PULSE_MEASURE_STATS_EN
  ,
  output logic [15:0]      fail_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] EXP_D     = CNT_W'(EXP_DELAY);
  localparam logic [CNT_W-1:0] EXP_W     = CNT_W'(EXP_WIDTH);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEASURE,
    REPORT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_next;
  logic             pulse_prev;
  logic             rise;

  logic [CNT_W-1:0] delay_next;
  logic [CNT_W-1:0] width_next;
  logic             delay_err_next;
  logic             width_err_next;
  logic             timeout_err_next;
  logic             valid_next;
  logic             accept;

`ifdef PULSE_MEASURE_STATS_EN
  logic [15:0]      fail_count_next;
`endif

  // Counters never wrap: a pulse longer than the counter range reports the
  // maximum value instead of a small wrapped width.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + CNT_ONE;
  endfunction

  // A pulse already high when the block arms produces no rise here, because
  // pulse_prev tracks pulse_in every cycle regardless of state.
  assign rise   = pulse_in & ~pulse_prev;
  assign accept = meas_valid & meas_ready;
  assign busy   = (state != IDLE);

  // ---- next-state / result computation ----
  always_comb begin
    state_next       = state;
    counter_next     = counter;
    delay_next       = meas_delay;
    width_next       = meas_width;
    delay_err_next   = delay_err;
    width_err_next   = width_err;
    timeout_err_next = timeout_err;
    valid_next       = meas_valid;

    case (state)
      IDLE: begin
        if (start) begin
          counter_next = CNT_ONE;
          state_next   = WAIT_RISE;
        end
      end

      WAIT_RISE: begin
        if (rise) begin
          delay_next   = counter;
          counter_next = CNT_ONE;
          state_next   = MEASURE;
        end else if (counter == TIMEOUT_C) begin
          delay_next       = TIMEOUT_C;
          width_next       = '0;
          delay_err_next   = 1'b1;
          width_err_next   = 1'b1;
          timeout_err_next = 1'b1;
          valid_next       = 1'b1;
          state_next       = REPORT;
        end else begin
          counter_next = sat_inc(counter);
        end
      end

      MEASURE: begin
        if (pulse_in) begin
          counter_next = sat_inc(counter);
        end else begin
          width_next       = counter;
          delay_err_next   = (meas_delay != EXP_D);
          width_err_next   = (counter != EXP_W);
          timeout_err_next = 1'b0;
          valid_next       = 1'b1;
          state_next       = REPORT;
        end
      end

      REPORT: begin
        // start is deliberately not looked at here, including on the
        // handshake edge, so a new run always needs a fresh start in IDLE.
        if (accept) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef PULSE_MEASURE_STATS_EN
  always_comb begin
    fail_count_next = fail_count;
    if (accept && (delay_err || width_err || timeout_err) && (fail_count != 16'hFFFF)) begin
      fail_count_next = fail_count + 16'd1;
    end
  end
`else
  // Statistics counter not built.
`endif

  // ---- registered state and result fields ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      pulse_prev  <= 1'b0;
      meas_delay  <= '0;
      meas_width  <= '0;
      delay_err   <= 1'b0;
      width_err   <= 1'b0;
      timeout_err <= 1'b0;
      meas_valid  <= 1'b0;
    end else begin
      state       <= state_next;
      counter     <= counter_next;
      pulse_prev  <= pulse_in;
      meas_delay  <= delay_next;
      meas_width  <= width_next;
      delay_err   <= delay_err_next;
      width_err   <= width_err_next;
      timeout_err <= timeout_err_next;
      meas_valid  <= valid_next;
    end
  end

`ifdef PULSE_MEASURE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_count <= '0;
    end else begin
      fail_count <= fail_count_next;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_measure.sv
// Directed bench for pulse_measure (TIMEOUT overridden to 20). Expected
// results are queued when a stimulus run is issued and popped for comparison
// when the block presents meas_valid. Edge numbers are counted from the edge
// that samples start (edge 0).

module tb_pulse_measure;

  localparam int CNT_W = 8;
  localparam int TO    = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             pulse_in;
  logic [CNT_W-1:0] meas_delay;
  logic [CNT_W-1:0] meas_width;
  logic             delay_err;
  logic             width_err;
  logic             timeout_err;
  logic             meas_valid;
  logic             meas_ready;
  logic             busy;
`ifdef PULSE_MEASURE_STATS_EN
  logic [15:0]      fail_count;
`endif

  pulse_measure #(
    .CNT_W    (CNT_W),
    .EXP_DELAY(3),
    .EXP_WIDTH(3),
    .TIMEOUT  (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pulse_in   (pulse_in),
    .meas_delay (meas_delay),
    .meas_width (meas_width),
    .delay_err  (delay_err),
    .width_err  (width_err),
    .timeout_err(timeout_err),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .busy       (busy)
`ifdef PULSE_MEASURE_STATS_EN
    ,
    .fail_count (fail_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0] d;
    logic [CNT_W-1:0] w;
    logic             de;
    logic             we;
    logic             te;
  } exp_t;

  exp_t sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   exp_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a completed pulse measurement against EXP_DELAY=3/EXP_WIDTH=3.
  task automatic push_pulse(input int d, input int w);
    exp_t e;
    e.d  = CNT_W'(d);
    e.w  = CNT_W'(w);
    e.de = (d != 3);
    e.we = (w != 3);
    e.te = 1'b0;
    sb.push_back(e);
  endtask

  task automatic chk_fields(input string tag, input exp_t e);
    chk({tag, "_delay"},   32'(meas_delay),  32'(e.d));
    chk({tag, "_width"},   32'(meas_width),  32'(e.w));
    chk({tag, "_derr"},    32'(delay_err),   32'(e.de));
    chk({tag, "_werr"},    32'(width_err),   32'(e.we));
    chk({tag, "_terr"},    32'(timeout_err), 32'(e.te));
  endtask

  // Start at edge 0; pulse high at edges [rise, rise+width), plus high at
  // edges [0, stale_fall) to model a pulse already high when armed.
  task automatic run_pulse(input string tag, input int stale_fall, input int rise, input int width);
    pulse_in = (stale_fall > 0);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    chk({tag, "_busy_armed"}, 32'(busy), 32'd1);
    for (int e = 1; e <= rise + width; e++) begin
      pulse_in = (e < stale_fall) || (e >= rise && e < rise + width);
      if (e == rise + width) chk({tag, "_valid_early"}, 32'(meas_valid), 32'd0);
      tick();
    end
    pulse_in = 1'b0;
    chk({tag, "_valid"}, 32'(meas_valid), 32'd1);
  endtask

  // Pop the scoreboard against the presented result, then accept it.
  task automatic handshake(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk_fields(tag, e);
      if (e.de || e.we || e.te) exp_fail++;
    end
    meas_ready = 1'b1;
    tick();
    chk({tag, "_valid_drop"}, 32'(meas_valid), 32'd0);
    chk({tag, "_busy_drop"},  32'(busy),       32'd0);
`ifdef PULSE_MEASURE_STATS_EN
    chk({tag, "_fail_count"}, 32'(fail_count), 32'(exp_fail));
`endif
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_delay"}, 32'(meas_delay),  32'd0);
    chk({tag, "_width"}, 32'(meas_width),  32'd0);
    chk({tag, "_derr"},  32'(delay_err),   32'd0);
    chk({tag, "_werr"},  32'(width_err),   32'd0);
    chk({tag, "_terr"},  32'(timeout_err), 32'd0);
    chk({tag, "_valid"}, 32'(meas_valid),  32'd0);
    chk({tag, "_busy"},  32'(busy),        32'd0);
`ifdef PULSE_MEASURE_STATS_EN
    chk({tag, "_fail_count"}, 32'(fail_count), 32'd0);
`endif
  endtask

  initial begin
    exp_t bp;
    exp_t tmo;

    reset      = 1'b1;
    start      = 1'b0;
    pulse_in   = 1'b0;
    meas_ready = 1'b1;
    tick();
    tick();
    chk_zero("reset");
    reset = 1'b0;
    tick();

    // 1. Nominal: high at edges 3,4,5.
    push_pulse(3, 3);
    run_pulse("nominal", 0, 3, 3);
    handshake("nominal");
    tick();

    // 2. Mismatch: rise at edge 5, high two cycles.
    push_pulse(5, 2);
    run_pulse("mismatch", 0, 5, 2);
    handshake("mismatch");
    tick();

    // 3. Timeout: no pulse at all.
    tmo.d  = CNT_W'(TO);
    tmo.w  = '0;
    tmo.de = 1'b1;
    tmo.we = 1'b1;
    tmo.te = 1'b1;
    sb.push_back(tmo);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= TO; e++) begin
      if (e == TO) chk("timeout_valid_early", 32'(meas_valid), 32'd0);
      tick();
    end
    chk("timeout_valid", 32'(meas_valid), 32'd1);
    handshake("timeout");
    tick();

    // 4. Backpressure with start/pulse activity while reporting.
    meas_ready = 1'b0;
    push_pulse(3, 3);
    run_pulse("bp", 0, 3, 3);
    bp = sb[0];
    for (int i = 0; i < 10; i++) begin
      start    = (i % 2 == 0);
      pulse_in = (i % 2 == 1);
      tick();
      chk("bp_hold_valid", 32'(meas_valid), 32'd1);
      chk("bp_hold_busy",  32'(busy),       32'd1);
      chk_fields("bp_hold", bp);
    end
    pulse_in = 1'b0;
    start    = 1'b1;   // held on the handshake edge: must not re-arm
    handshake("bp");
    start = 1'b0;
    tick();
    chk("bp_no_rearm_busy",  32'(busy),       32'd0);
    chk("bp_no_rearm_valid", 32'(meas_valid), 32'd0);
    tick();

    // 5. Reset while in the high phase of a pulse.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      pulse_in = (e >= 3);
      tick();
    end
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    pulse_in = 1'b0;
    exp_fail = 0;
    chk_zero("midreset");
    tick();
    push_pulse(3, 3);
    run_pulse("post_reset", 0, 3, 3);
    handshake("post_reset");
    tick();

    // 6. Pulse already high when armed, falls at 2, rises at 4 for 3 cycles.
    push_pulse(4, 3);
    run_pulse("stale", 2, 4, 3);
    handshake("stale");
`ifdef PULSE_MEASURE_STATS_EN
    chk("stale_fail_count_one", 32'(fail_count), 32'd1);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_measure.md
Name: pulse_measure

Overview:
Receive-side counterpart to the team's start-triggered pulse generator. The block arms on a start strobe and measures two values on a single-bit pulse input in the same clock domain. The first value is the start-to-rising-edge delay; the second is the high width. It compares both against expected values and presents one result word through a valid/ready handshake. Its uses are self-checking loopback in benches and on-chip monitoring of generator timing.

Parameters:
CNT_W, 8, width of the delay and width counters and of the result fields.
EXP_DELAY, 3, expected delay in clocks. Legal range 1..2^CNT_W-1.
EXP_WIDTH, 3, expected pulse width in clocks. Legal range 1..2^CNT_W-1.
TIMEOUT, 255, maximum delay count before giving up. Legal range 1..2^CNT_W-1.

Ports:
clk  in  1  clock; all logic is rising-edge.
reset  in  1  synchronous, active-high reset.
start  in  1  arm request; sampled only in IDLE.
pulse_in  in  1  monitored pulse; synchronous to clk.
meas_delay  out  CNT_W  measured start-to-rise delay.
meas_width  out  CNT_W  measured high width.
delay_err  out  1  meas_delay != EXP_DELAY.
width_err  out  1  meas_width != EXP_WIDTH.
timeout_err  out  1  no rising edge seen within TIMEOUT.
meas_valid  out  1  result fields valid.
meas_ready  in  1  consumer accepts the result.
busy  out  1  high when state != IDLE.

Behaviour:
- Reset:
  - All outputs go to 0.
  - State goes to IDLE.
  - Counter goes to 0.
  - pulse_prev goes to 0.
  - Reset applies from any state, including mid-measurement and mid-handshake; any partial result is discarded.
- pulse_prev register: captures pulse_in every cycle. rise = pulse_in & ~pulse_prev.
- States: IDLE, WAIT_RISE, MEASURE, REPORT.
- IDLE:
  - start=1 sets counter<=1 and moves to WAIT_RISE.
  - Any pulse activity in IDLE is ignored.
- WAIT_RISE, evaluated in priority order:
  1. rise: meas_delay<=counter, counter<=1, go to MEASURE.
  2. else if counter==TIMEOUT: meas_delay<=TIMEOUT, meas_width<=0, timeout_err, delay_err and width_err all <=1, meas_valid<=1, go to REPORT.
  3. else counter<=counter+1.
  - A pulse already high when start is sampled is not counted; a fresh rising edge is required.
- MEASURE:
  - pulse_in=1: counter increments and saturates at 2^CNT_W-1. No timeout applies in MEASURE.
  - pulse_in=0: meas_width<=counter, delay_err<=(meas_delay!=EXP_DELAY), width_err<=(counter!=EXP_WIDTH), timeout_err<=0, meas_valid<=1, go to REPORT.
- REPORT:
  - All result outputs hold stable while meas_valid=1 && meas_ready=0.
  - meas_valid&&meas_ready at an edge: meas_valid<=0, go to IDLE. Result fields keep their last values.
  - start is ignored in REPORT; it is also ignored on the handshake edge itself.
- Timing: a pulse high for W consecutive sampling edges reports meas_width=W. meas_valid rises on the edge after the first low sample.
- busy is registered-state decode: high from the edge after start is accepted until the handshake edge.
- Widths: all counters are CNT_W bits with no wrap; counters saturate.

Optional Feature:
PULSE_MEASURE_STATS_EN.
- Defined:
  - Adds output fail_count, out, 16 bits.
  - Increments on each accepted result (valid&&ready) with any error flag set.
  - Saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
All scenarios use defaults except TIMEOUT=20.
1. Nominal pulse: start at edge 0; pulse_in high sampled at edges 3,4,5; meas_ready=1. Required: meas_valid=1 after edge 6; meas_delay=3, meas_width=3; all error flags 0; busy=0 after edge 7.
2. Mismatch: pulse_in rises at edge 5 and is high 2 cycles. Required: meas_delay=5, meas_width=2, delay_err=1, width_err=1, timeout_err=0.
3. Timeout: start with pulse_in held 0. Required: after edge 20, meas_valid=1, meas_delay=20, meas_width=0, all three error flags 1.
4. Backpressure: complete a measurement with meas_ready=0 for 10 cycles while toggling start and pulse_in. Required: outputs stable and meas_valid held. Raise meas_ready; then meas_valid=0 after the next edge, busy=0, and no new measurement has started.
5. Reset mid-MEASURE: assert reset for 1 cycle during the pulse high phase. Required: all outputs 0 and state IDLE. A following nominal run reports 3/3 with no errors.
6. Stale high: pulse_in already 1 when start is sampled, falls at edge 2, rises at edge 4 for 3 cycles. Required: meas_delay=4, meas_width=3. With STATS_EN defined, fail_count=1 after the handshake.
